// File: rtl/button_gesture_pkg.sv
// rtl/button_gesture_pkg.sv - gesture decoder state type and counter sizing helper
package button_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } gesture_state_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ms_tick_counter.sv
// rtl/ms_tick_counter.sv - ce1ms tick counter flagging the Nth tick of a limit
module ms_tick_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce1ms,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic             hit
);

  logic [WIDTH-1:0] cnt;

  // The Nth tick is the one that arrives while cnt still holds N-1.
  assign hit = ce1ms && (cnt == limit - WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ce1ms) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/button_gesture_decoder.sv
// rtl/button_gesture_decoder.sv - decodes a debounced button level into press/click/hold events
module button_gesture_decoder
  import button_gesture_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic ce1ms,
  input  logic btn,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  localparam int W = cnt_width(LONG_MS, DOUBLE_MS, REPEAT_MS);

  gesture_state_t state;
  logic           btn_q;
  logic           rise;
  logic           fall;
  logic           hit;
  logic           clr;
  logic [W-1:0]   limit;

  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  // Clearing on the edge as well as on the hit makes an edge swallow a
  // coincident tick; IDLE and PRESS2 pin the counter at zero.
  always_comb begin
    clr   = 1'b1;
    limit = W'(LONG_MS);
    case (state)
      PRESS1: begin clr = fall | hit; limit = W'(LONG_MS);   end
      HOLD:   begin clr = fall | hit; limit = W'(REPEAT_MS); end
      GAP:    begin clr = rise | hit; limit = W'(DOUBLE_MS); end
      default: begin clr = 1'b1; limit = W'(LONG_MS); end
    endcase
  end

  ms_tick_counter #(.WIDTH(W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .ce1ms (ce1ms),
    .clr   (clr),
    .limit (limit),
    .hit   (hit)
  );

  // btn_q resets high so a button held across reset must be released first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      btn_q        <= 1'b1;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      btn_q        <= btn;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= (state != IDLE);
      case (state)
        IDLE: begin
          if (rise) state <= PRESS1;
        end
        PRESS1: begin
          if (fall) begin
            state <= GAP;
          end else if (hit) begin
            long_press <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (fall) begin
            state <= IDLE;
          end else if (hit) begin
            repeat_pulse <= 1'b1;
          end
        end
        GAP: begin
          if (rise) begin
            state <= PRESS2;
          end else if (hit) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end
        end
        PRESS2: begin
          if (fall) begin
            double_click <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// tb/tb_button_gesture_decoder.sv - directed and random checks of the gesture decoder
module tb_button_gesture_decoder;

  localparam int L = 8;
  localparam int D = 4;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce1ms = 1'b0;
  logic btn = 1'b0;
  logic short_press, double_click, long_press, repeat_pulse, busy;

  button_gesture_decoder #(.LONG_MS(L), .DOUBLE_MS(D), .REPEAT_MS(R)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce1ms        (ce1ms),
    .btn          (btn),
    .short_press  (short_press),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: a gesture is a run of presses; ticks counted since the last edge.
  bit m_active, m_down, m_long, m_prev;
  int m_presses, m_ticks;
  bit e_short, e_dbl, e_long, e_rep, e_busy;
  int ph = 0;
  bit ce_all = 0;
  int n_short, n_dbl, n_long, n_rep, n_busy;

  task automatic model_reset();
    m_active = 0; m_down = 0; m_long = 0; m_prev = 1;
    m_presses = 0; m_ticks = 0;
    e_short = 0; e_dbl = 0; e_long = 0; e_rep = 0; e_busy = 0;
  endtask

  task automatic model_step(input bit b, input bit ce);
    bit r, f;
    r = b && !m_prev;
    f = !b && m_prev;
    e_busy = m_active;
    e_short = 0; e_dbl = 0; e_long = 0; e_rep = 0;
    if (!m_active) begin
      if (r) begin
        m_active = 1; m_presses = 1; m_down = 1; m_long = 0; m_ticks = 0;
      end
    end else if (m_long) begin
      if (f) m_active = 0;
      else if (ce) begin
        m_ticks++;
        if (m_ticks % R == 0) e_rep = 1;
      end
    end else if (m_down) begin
      if (f) begin
        if (m_presses == 2) begin e_dbl = 1; m_active = 0; end
        else begin m_down = 0; m_ticks = 0; end
      end else if (m_presses == 1 && ce) begin
        m_ticks++;
        if (m_ticks == L) begin e_long = 1; m_long = 1; m_ticks = 0; end
      end
    end else begin
      if (r) begin m_presses = 2; m_down = 1; m_ticks = 0; end
      else if (ce) begin
        m_ticks++;
        if (m_ticks == D) begin e_short = 1; m_active = 0; end
      end
    end
    m_prev = b;
  endtask

  task automatic clr_counts();
    n_short = 0; n_dbl = 0; n_long = 0; n_rep = 0; n_busy = 0;
  endtask

  task automatic compare_outputs();
    check("short_press", short_press, e_short);
    check("double_click", double_click, e_dbl);
    check("long_press", long_press, e_long);
    check("repeat", repeat_pulse, e_rep);
    check("busy", busy, e_busy);
    n_short += short_press; n_dbl += double_click;
    n_long += long_press; n_rep += repeat_pulse; n_busy += busy;
  endtask

  task automatic cyc(input bit b, input bit force_ce = 0);
    btn = b;
    ce1ms = ce_all || (ph == 5) || force_ce;
    ph = (ph + 1) % 6;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(btn, ce1ms);
    #1;
    compare_outputs();
  endtask

  task automatic hold(input bit b, input int n);
    int k;
    k = 0;
    while (k < n) begin
      cyc(b);
      if (ce1ms) k++;
    end
  endtask

  task automatic expect_counts(input string tag, input int s, input int d, input int l, input int r);
    check({tag, "_short"}, n_short, s);
    check({tag, "_double"}, n_dbl, d);
    check({tag, "_long"}, n_long, l);
    check({tag, "_repeat"}, n_rep, r);
  endtask

  initial begin
    model_reset();
    clr_counts();
    cyc(0); cyc(0);
    check("reset_busy", busy, 0);
    check("reset_short", short_press, 0);
    rst = 1'b0;
    hold(0, 2);

    clr_counts(); hold(1, 3); hold(0, 6);
    expect_counts("short", 1, 0, 0, 0);
    check("short_busy_idle", busy, 0);

    clr_counts(); hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 6);
    expect_counts("double", 0, 1, 0, 0);

    clr_counts(); hold(1, 14); hold(0, 6);
    expect_counts("long", 0, 0, 1, 3);

    rst = 1'b1; cyc(1); cyc(1); rst = 1'b0;
    clr_counts(); hold(1, 20); hold(0, 6);
    expect_counts("heldrst", 0, 0, 0, 0);
    check("heldrst_busy_cycles", n_busy, 0);
    clr_counts(); hold(1, 3); hold(0, 6);
    expect_counts("after_heldrst", 1, 0, 0, 0);

    // Rise lands on the 4th gap tick: edge must win.
    clr_counts(); hold(1, 2); hold(0, 3);
    while (ph != 5) cyc(0);
    cyc(1);
    check("collision_ce", ce1ms, 1);
    hold(1, 1); hold(0, 6);
    expect_counts("collision", 0, 1, 0, 0);

    clr_counts(); hold(1, 2);
    rst = 1'b1; #1;
    model_reset();
    check("async_rst_busy", busy, 0);
    check("async_rst_long", long_press, 0);
    cyc(1); cyc(1); rst = 1'b0;
    hold(1, 2); hold(0, 6);
    expect_counts("midrst", 0, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      int n;
      bit b;
      if ($urandom_range(0, 9) == 0) ce_all = !ce_all;
      b = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 60);
      for (int j = 0; j < n; j++) cyc(b);
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1; cyc(b); rst = 1'b0;
      end
    end
    ce_all = 0;
    hold(0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
